// File: rtl/kernel_a_stream_feeder.sv
// kernel_a_stream_feeder: buffers two streams, feeds aligned pairs into kernel_A and tracks in-flight elements
module kernel_a_stream_feeder #(
  parameter int DATAW      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int KLAT       = 2,
  parameter int NELEM      = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DATAW-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [DATAW-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [DATAW-1:0] ka_vin0,
  output logic [DATAW-1:0] ka_vin1,
  output logic             stall,
  input  logic             out_ready,
  output logic             kout_valid,
  output logic             busy,
  output logic             done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(NELEM + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_n;
  logic [1:0][DATAW-1:0]   din, head;
  logic [1:0]              vld, full, empty;
  logic [CW-1:0]           issued, retired;
  logic [KLAT-1:0]         vsr;
  logic                    advance, inject, retire;

  assign din        = {in1_data, in0_data};
  assign vld        = {in1_valid, in0_valid};
  assign in0_ready  = !full[0];
  assign in1_ready  = !full[1];
  assign advance    = out_ready && (state == RUN || state == DRAIN);
  assign inject     = advance && state == RUN && !empty[0] && !empty[1] && issued < CW'(NELEM);
  assign retire     = kout_valid && out_ready;
  assign stall      = !advance;
  assign ka_vin0    = inject ? head[0] : '0;
  assign ka_vin1    = inject ? head[1] : '0;
  assign kout_valid = vsr[KLAT-1];

  generate
    for (genvar s = 0; s < 2; s++) begin : g_fifo
      logic [DATAW-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]    wp, rp;
      assign full[s]  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
      assign empty[s] = wp == rp;
      assign head[s]  = mem[rp[AW-1:0]];
      // storage needs no reset: the pointers alone define what is valid
      always_ff @(posedge clk)
        if (vld[s] && !full[s]) mem[wp[AW-1:0]] <= din[s];
      // push only when not full (a same-cycle pop does not free a slot), pop on inject
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          wp <= '0;
          rp <= '0;
        end else begin
          wp <= wp + PW'(vld[s] && !full[s]);
          rp <= rp + PW'(inject);
        end
    end
  endgenerate

  // state, run counters, valid tracker and registered status flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      issued  <= '0;
      retired <= '0;
      vsr     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      issued  <= state == IDLE ? '0 : issued + CW'(inject);
      retired <= state == IDLE ? '0 : retired + CW'(retire);
      if (advance) vsr <= KLAT'({vsr, inject});
      done    <= state_n == DONE;
      busy    <= state_n == RUN || state_n == DRAIN;
    end

  // run sequencing: inject NELEM elements, drain until all retire, pulse done
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = inject && issued == CW'(NELEM - 1) ? DRAIN : RUN;
      DRAIN:   state_n = retire && retired == CW'(NELEM - 1) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/kernel_a_stream_feeder.md
# kernel_a_stream_feeder

Upstream feeder and flow controller for the kernel_A pipeline. Buffers two independent valid/ready input streams in small FIFOs and issues aligned element pairs onto `ka_vin0`/`ka_vin1`. Drives the kernel's `stall` and tracks in-flight elements with a valid shift register matched to kernel latency, so `ka_vout` is qualified by `kout_valid`. Sequences one run of NELEM elements per `start` and reports `done`.

## Interface
- DATAW, 32, element width (matches kernel DATAW)
- FIFO_DEPTH, 4, per-stream FIFO depth; power of two, ≥2
- KLAT, 2, kernel latency in non-stalled cycles (local1 stage + ka_vout stage)
- NELEM, 1024, elements per run; counters are $clog2(NELEM+1) bits

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- in0_data  in  DATAW  stream 0 data
- in0_valid  in  1  stream 0 valid
- in0_ready  out  1  stream 0 ready
- in1_data / in1_valid / in1_ready: as stream 0, for stream 1
- ka_vin0  out  DATAW  to kernel `ka_vin0`
- ka_vin1  out  DATAW  to kernel `ka_vin1`
- stall  out  1  to kernel `stall`; 1 freezes the kernel pipeline
- out_ready  in  1  downstream consumer of `ka_vout` can accept
- kout_valid  out  1  `ka_vout` holds a real element this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  one-cycle pulse at run completion

## Operation
- FIFOs: `inX_ready = !fullX` in every state; a push occurs on `inX_valid && inX_ready`. Push into a full FIFO is blocked even if a pop occurs the same cycle. Pre-fetch is allowed in IDLE/DONE; data persists across runs.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start` -> RUN; clears `issued` and `retired`.
  - RUN -> DRAIN: on the cycle the NELEM-th element is injected.
  - DRAIN -> DONE: when `retired` reaches NELEM.
  - DONE -> IDLE: unconditionally after one cycle; `done` = 1 only in DONE.
  - `start` outside IDLE is ignored.
- `advance = out_ready && (state==RUN || state==DRAIN)`.
- `stall = !advance`.
- `inject = advance && state==RUN && !empty0 && !empty1 && issued<NELEM`.
  - On inject, pop one word from each FIFO and increment `issued`.
  - `ka_vinX` = FIFO head when inject, else 0.
- Bubble: an advance cycle without inject shifts a 0 into the valid tracker.
- Valid tracker: KLAT-bit shift register `vsr`, shifted only on advance, input = inject. `kout_valid = vsr[KLAT-1]`.
- Retire: `kout_valid && out_ready` increments `retired`.
- Stall semantics: when `out_ready` = 0, the kernel, `vsr`, and the FIFO pops all freeze. `kout_valid` and `ka_vout` hold their values.

## Timing
- Reset (async assert, sync-released use): FIFOs empty, state IDLE, `vsr` = 0, counters = 0, `done` = 0, `busy` = 0, `kout_valid` = 0, `stall` = 1, `ka_vin*` = 0, `in*_ready` = 1.
- Reset mid-run aborts the run and discards all buffered and in-flight data.
- `stall`, `ka_vin*`, and `inX_ready` are combinational from state, FIFO flags/heads, and `out_ready`. `kout_valid`, `done`, and `busy` come from registers.
- Latency: with `out_ready` held high, an element injected in cycle t appears with `kout_valid` = 1 in cycle t+KLAT.
- FIFO write-to-read latency: a word pushed in cycle t is poppable in t+1.
- Throughput: one element per cycle when both streams are valid and `out_ready` = 1.
- Start-to-done: with both FIFOs full at start and `out_ready` = 1, RUN is entered at cycle 1 and `done` pulses at cycle NELEM+KLAT+1 (±1 for the DONE register).

## Test plan
- Reset: drive `rst` = 0 mid-run with pushes pending -> all outputs at reset values and FIFOs empty. After release, `in0_ready` = `in1_ready` = 1.
- Streaming, NELEM=8, KLAT=2: both streams supply 1..8 continuously, `out_ready` = 1, pulse `start`.
  - `kout_valid` is high for exactly 8 consecutive cycles, starting 2 cycles after the first inject.
  - `done` pulses once, then the FSM returns to IDLE.
- Skewed streams: stream 1 lags stream 0 by 3 cycles.
  - Stream 0 FIFO fills; `in0_ready` = 0 while it is full.
  - Bubbles are issued (`ka_vin*` = 0, `vsr` input 0), and pairs stay aligned by index.
- Backpressure: drop `out_ready` for 5 cycles mid-run -> `stall` = 1 for those 5 cycles.
  - `ka_vout` and `kout_valid` are held, and no pops occur.
  - On resume no element is lost or duplicated; the count retired is 8.
- Start ignored, prefetch: pulse `start` during RUN -> no effect.
  - Push 4 words per stream while in IDLE; a second `start` consumes them immediately at full rate.
- Full FIFO boundary: with FIFO_DEPTH=4 and FIFO 0 full, assert `in0_valid` in the same cycle as a pop -> no push that cycle (`in0_ready` = 0); the push is accepted the next cycle.
